regfile_wr_arbiter: RTL and testbench

- Shares the register file's single write port (Wr_idx / Data_in / Wr_en) between two write-back requesters.
  - Port A: ALU write-back.
  - Port B: load/CSR write-back.
- Buffers one request per requester, arbitrates round-robin, and preserves write order to the same register.
- Publishes a pending-write mask and read-port hazard flags so the decode/issue stage can stall reads of registers not yet committed.
- Sits between the execute/memory stages and the register file top.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_wr_arbiter_wr_hold_slot.sv | 34 +++
 rtl/regfile_wr_arbiter.sv | 152 +++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: widths, zero-register constant,
// and the write-back requester identifiers.
package regfile_pkg;

  localparam int IDX_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 2 ** IDX_W;

  localparam logic [IDX_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/regfile_wr_arbiter_wr_hold_slot.sv
// Single-entry write-back holding buffer (valid/idx/data).
// Ports: clk, rst (sync high), load (capture), clr (retire),
//        load_idx/load_data in, hv/hidx/hdata held contents out.
module wr_hold_slot #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  output logic              hv,
  output logic [IDX_W-1:0]  hidx,
  output logic [DATA_W-1:0] hdata
);

  // load beats clr: a granted slot refilled in the same cycle stays valid
  always_ff @(posedge clk) begin
    if (rst) begin
      hv    <= 1'b0;
      hidx  <= '0;
      hdata <= '0;
    end else if (load) begin
      hv    <= 1'b1;
      hidx  <= load_idx;
      hdata <= load_data;
    end else if (clr) begin
      hv    <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester register-file write-port arbiter with hazard mask.
// Ports: clk, rst (sync high); a_*/b_* valid/ready/idx/data requesters;
//   Wr_en/Wr_idx/Data_in to the register file; R1_idx/R2_idx in,
//   r1_hazard/r2_hazard/pend_mask out. Optional WR_ARB_STATS_EN adds
//   stat_conflicts and stat_x0_drops saturating counters.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int IDX_W  = regfile_pkg::IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [IDX_W-1:0]      a_idx,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [IDX_W-1:0]      b_idx,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  Wr_en,
  output logic [IDX_W-1:0]      Wr_idx,
  output logic [DATA_W-1:0]     Data_in,
  input  logic [IDX_W-1:0]      R1_idx,
  input  logic [IDX_W-1:0]      R2_idx,
  output logic                  r1_hazard,
  output logic                  r2_hazard,
  output logic [2**IDX_W-1:0]   pend_mask
`ifdef WR_ARB_STATS_EN
  ,
  output logic [31:0]           stat_conflicts,
  output logic [31:0]           stat_x0_drops
`endif
);

  localparam int NR = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] ZERO = IDX_W'(REG_ZERO);

  logic              hv_a, hv_b;
  logic [IDX_W-1:0]  hidx_a, hidx_b;
  logic [DATA_W-1:0] hdata_a, hdata_b;
  logic              load_a, load_b;
  logic              grant_a, grant_b, grant_any;
  logic              same_idx, a_wins;
  logic [IDX_W-1:0]  g_idx;
  logic [DATA_W-1:0] g_data;
  req_e              rr_ptr;
  logic              old_b;

  assign load_a = a_valid & a_ready;
  assign load_b = b_valid & b_ready;

  wr_hold_slot #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a),
    .clr       (grant_a),
    .load_idx  (a_idx),
    .load_data (a_data),
    .hv        (hv_a),
    .hidx      (hidx_a),
    .hdata     (hdata_a)
  );

  wr_hold_slot #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b),
    .clr       (grant_b),
    .load_idx  (b_idx),
    .load_data (b_data),
    .hv        (hv_b),
    .hidx      (hidx_b),
    .hdata     (hdata_b)
  );

  // Same destination: oldest first keeps write order; else round-robin
  assign same_idx = (hidx_a == hidx_b) && (hidx_a != ZERO);
  assign a_wins   = same_idx ? ~old_b : (rr_ptr == REQ_A);

  assign grant_a   = hv_a & (~hv_b | a_wins);
  assign grant_b   = hv_b & (~hv_a | ~a_wins);
  assign grant_any = grant_a | grant_b;

  // Ready depends only on registered slot state
  assign a_ready = ~hv_a | grant_a;
  assign b_ready = ~hv_b | grant_b;

  always_comb begin
    g_idx  = '0;
    g_data = '0;
    unique case (1'b1)
      grant_a: begin
        g_idx  = hidx_a;
        g_data = hdata_a;
      end
      grant_b: begin
        g_idx  = hidx_b;
        g_data = hdata_b;
      end
      default: ;
    endcase
  end

  assign Wr_idx  = g_idx;
  assign Data_in = g_data;
  assign Wr_en   = grant_any & (g_idx != ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= REQ_A;
      old_b  <= 1'b0;
    end else begin
      if (hv_a & hv_b)
        rr_ptr <= grant_a ? REQ_B : REQ_A;
      // old_b: B's held entry predates A's
      if (load_a & load_b)
        old_b <= 1'b0;
      else if (load_a)
        old_b <= hv_b & ~grant_b;
      else if (load_b)
        old_b <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 1; i < NR; i++) begin
      pend_mask[i] = (hv_a && (hidx_a == IDX_W'(i))) ||
                     (hv_b && (hidx_b == IDX_W'(i)));
    end
  end

  assign r1_hazard = pend_mask[R1_idx];
  assign r2_hazard = pend_mask[R2_idx];

`ifdef WR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conflicts <= '0;
      stat_x0_drops  <= '0;
    end else begin
      if (hv_a && hv_b && (stat_conflicts != '1))
        stat_conflicts <= stat_conflicts + 32'd1;
      if (grant_any && (g_idx == ZERO) && (stat_x0_drops != '1))
        stat_x0_drops <= stat_x0_drops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed writes, contention,
// x0, hazards, streaming and mid-stream reset.
module tb_regfile_wr_arbiter;

  localparam int IW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [IW-1:0] a_idx = '0, b_idx = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          Wr_en;
  logic [IW-1:0] Wr_idx;
  logic [DW-1:0] Data_in;
  logic [IW-1:0] R1_idx = '0, R2_idx = '0;
  logic          r1_hazard, r2_hazard;
  logic [31:0]   pend_mask;
`ifdef WR_ARB_STATS_EN
  logic [31:0]   stat_conflicts, stat_x0_drops;
`endif

  int  vecs = 0;
  int  miss = 0;
  wr_t exp_q[$];
  logic [DW-1:0] rf [32];

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_idx     (a_idx),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_idx     (b_idx),
    .b_data    (b_data),
    .Wr_en     (Wr_en),
    .Wr_idx    (Wr_idx),
    .Data_in   (Data_in),
    .R1_idx    (R1_idx),
    .R2_idx    (R2_idx),
    .r1_hazard (r1_hazard),
    .r2_hazard (r2_hazard),
    .pend_mask (pend_mask)
`ifdef WR_ARB_STATS_EN
    ,
    .stat_conflicts (stat_conflicts),
    .stat_x0_drops  (stat_x0_drops)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [IW-1:0] i, input logic [DW-1:0] d);
    wr_t w;
    w.idx  = i;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every register-file write must match the next expected one
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (Wr_en === 1'b1) begin
        vecs++;
        rf[Wr_idx] = Data_in;
        if (exp_q.size() == 0) begin
          miss++;
          $display("FAIL wr_unexpected: got idx %0d data %h want none",
                   Wr_idx, Data_in);
        end else begin
          e = exp_q.pop_front();
          if (Wr_idx !== e.idx || Data_in !== e.data) begin
            miss++;
            $display("FAIL wr_order: got idx %0d data %h want idx %0d data %h",
                     Wr_idx, Data_in, e.idx, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Both requesters stream n items; optional reset at driver cycle rst_at
  task automatic stream(input int n, input int rst_at);
    int ia = 0;
    int ib = 0;
    bit ta = 1'b0;
    bit tb = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ta) ia++;
      if (tb) ib++;
      if (c == rst_at) begin
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        break;
      end
      if (ia >= n && ib >= n) begin
        a_valid = 1'b0;
        b_valid = 1'b0;
        break;
      end
      a_valid = (ia < n);
      a_idx   = IW'(8 + ia);
      a_data  = 32'hA000_0000 + 32'(ia);
      b_valid = (ib < n);
      b_idx   = IW'(16 + ib);
      b_data  = 32'hB000_0000 + 32'(ib);
      ta = a_valid & a_ready;
      tb = b_valid & b_ready;
    end
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", 32'(Wr_en), 32'd0);
    chk("rst_wr_idx", 32'(Wr_idx), 32'd0);
    chk("rst_data_in", Data_in, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_haz", {30'd0, r1_hazard, r2_hazard}, 32'd0);
    chk("rst_ready", {30'd0, a_ready, b_ready}, 32'd3);

    // Single A write
    a_valid = 1'b1; a_idx = 5'd1; a_data = 32'hDEAD_BEEF;
    chk("t1_a_ready", 32'(a_ready), 32'd1);
    push(5'd1, 32'hDEAD_BEEF);
    @(negedge clk);
    a_valid = 1'b0;
    chk("t1_pend", pend_mask, 32'h0000_0002);
    @(negedge clk);
    chk("t1_pend_clr", pend_mask, 32'd0);

    // Simultaneous A and B, round-robin starts at A
    reset_dut();
    a_valid = 1'b1; a_idx = 5'd2; a_data = 32'h1234_5678;
    b_valid = 1'b1; b_idx = 5'd3; b_data = 32'hCAFE_F00D;
    push(5'd2, 32'h1234_5678);
    push(5'd3, 32'hCAFE_F00D);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t2_b_ready_lose", 32'(b_ready), 32'd0);
    chk("t2_pend", pend_mask, 32'h0000_000C);
    @(negedge clk);
    chk("t2_b_ready_win", 32'(b_ready), 32'd1);
    @(negedge clk);
    chk("t2_pend_clr", pend_mask, 32'd0);

    // Same register from both sides: older B entry must commit first
    reset_dut();
    a_valid = 1'b1; a_idx = 5'd4; a_data = 32'h4444_4444;
    b_valid = 1'b1; b_idx = 5'd5; b_data = 32'h1111_1111;
    push(5'd4, 32'h4444_4444);
    push(5'd5, 32'h1111_1111);
    push(5'd5, 32'h2222_2222);
    @(negedge clk);
    b_valid = 1'b0;
    a_idx = 5'd5; a_data = 32'h2222_2222;
    chk("t3_a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("t3_a_held", 32'(a_ready), 32'd0);
    chk("t3_pend", pend_mask, 32'h0000_0020);
    idle(2);
    chk("t3_final", rf[5], 32'h2222_2222);
    chk("t3_pend_clr", pend_mask, 32'd0);

    // x0 write retires silently
    reset_dut();
    a_valid = 1'b1; a_idx = 5'd0; a_data = 32'hFFFF_FFFF;
    chk("t4_a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("t4_wr_en", 32'(Wr_en), 32'd0);
    chk("t4_pend", pend_mask, 32'd0);
`ifdef WR_ARB_STATS_EN
    @(negedge clk);
    chk("t4_x0_drops", stat_x0_drops, 32'd1);
`endif
    @(negedge clk);
    chk("t4_wr_en_after", 32'(Wr_en), 32'd0);

    // Read hazards
    reset_dut();
    R1_idx = 5'd7; R2_idx = 5'd0;
    a_valid = 1'b1; a_idx = 5'd7; a_data = 32'h7777_7777;
    push(5'd7, 32'h7777_7777);
    @(negedge clk);
    a_valid = 1'b0;
    chk("t5_r1_haz", 32'(r1_hazard), 32'd1);
    chk("t5_r2_haz", 32'(r2_hazard), 32'd0);
    @(negedge clk);
    chk("t5_r1_haz_clr", 32'(r1_hazard), 32'd0);
    chk("t5_r2_haz_clr", 32'(r2_hazard), 32'd0);
    R1_idx = 5'd0;

    // Continuous streaming: A,B alternate one write per cycle
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      push(IW'(8 + k), 32'hA000_0000 + 32'(k));
      push(IW'(16 + k), 32'hB000_0000 + 32'(k));
    end
    stream(8, -1);
    idle(3);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream discards held entries
    reset_dut();
    push(5'd8, 32'hA000_0000);
    push(5'd16, 32'hB000_0000);
    push(5'd9, 32'hA000_0001);
    stream(8, 3);
    @(negedge clk);
    rst = 1'b0;
    chk("t7_wr_en", 32'(Wr_en), 32'd0);
    chk("t7_pend", pend_mask, 32'd0);
    chk("t7_ready", {30'd0, a_ready, b_ready}, 32'd3);
    idle(3);
    chk("t7_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
